// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared
// memory port with a ready handshake, retired-instruction counter and sticky halt.
module multicycle_cpu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i,
  input  logic                 mem_ready_i,
  output logic [31:0]          pc_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 halt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_t                 state_r;
  logic [31:0]            pc_r;
  logic [31:0]            npc_r;
  logic [31:0]            ir_r;
  logic [31:0]            a_r;
  logic [31:0]            b_r;
  logic [31:0]            alu_out_r;
  logic [31:0]            mdr_r;
  logic [INSTRET_W-1:0]   instret_r;
  logic                   halt_r;
  logic                   req_r;
  logic                   we_r;
  logic [31:0]            addr_r;
  logic [31:0]            wdata_r;
  logic [31:0]            rf_r [32];

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [31:0] imm_s;
  logic [31:0] rs_val_s;
  logic [31:0] rt_val_s;
  logic [31:0] jump_target_s;
  logic [31:0] branch_target_s;
  logic        legal_s;
  logic        is_jr_s;
  logic [31:0] alu_s;
  logic        take_branch_s;
  logic [4:0]  dest_s;
  logic [31:0] wb_data_s;

  assign mem_req_o   = req_r;
  assign mem_we_o    = we_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign pc_o        = pc_r;
  assign instret_o   = instret_r;
  assign halt_o      = halt_r;

  // Instruction field extraction and register-file read ports ($0 forced to zero).
  always_comb begin
    opcode_s        = ir_r[31:26];
    funct_s         = ir_r[5:0];
    rs_s            = ir_r[25:21];
    rt_s            = ir_r[20:16];
    rd_s            = ir_r[15:11];
    imm_s           = {{16{ir_r[15]}}, ir_r[15:0]};
    rs_val_s        = (rs_s == 5'd0) ? 32'd0 : rf_r[rs_s];
    rt_val_s        = (rt_s == 5'd0) ? 32'd0 : rf_r[rt_s];
    jump_target_s   = {npc_r[31:28], ir_r[25:0], 2'b00};
    branch_target_s = npc_r + {imm_s[29:0], 2'b00};
    dest_s          = (opcode_s == OP_RTYPE) ? rd_s : rt_s;
    wb_data_s       = (opcode_s == OP_LW) ? mdr_r : alu_out_r;
  end

  // Legality decode: anything outside the supported subset halts the core.
  always_comb begin
    legal_s = 1'b0;
    is_jr_s = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: legal_s = 1'b1;
          F_JR: begin
            legal_s = 1'b1;
            is_jr_s = 1'b1;
          end
          default: legal_s = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW: legal_s = 1'b1;
      default: legal_s = 1'b0;
    endcase
  end

  // ALU and branch comparison on the operands latched in DECODE.
  always_comb begin
    alu_s = 32'd0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          F_ADD:   alu_s = a_r + b_r;
          F_SUB:   alu_s = a_r - b_r;
          F_AND:   alu_s = a_r & b_r;
          F_OR:    alu_s = a_r | b_r;
          F_SLT:   alu_s = {31'd0, $signed(a_r) < $signed(b_r)};
          default: alu_s = 32'd0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_s = a_r + imm_s;
      OP_SLTI: alu_s = {31'd0, $signed(a_r) < $signed(imm_s)};
      default: alu_s = 32'd0;
    endcase
    if (opcode_s == OP_BEQ) begin
      take_branch_s = (a_r == b_r);
    end else begin
      take_branch_s = (a_r != b_r);
    end
  end

  // Control FSM plus all architectural state; memory port outputs are registered so
  // they are set up on the edge that enters FETCH/MEM and held until ready.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= S_IDLE;
      pc_r      <= RESET_PC;
      npc_r     <= 32'd0;
      ir_r      <= 32'd0;
      a_r       <= 32'd0;
      b_r       <= 32'd0;
      alu_out_r <= 32'd0;
      mdr_r     <= 32'd0;
      instret_r <= '0;
      halt_r    <= 1'b0;
      req_r     <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      for (int i = 0; i < 32; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_FETCH;
          req_r   <= 1'b1;
          we_r    <= 1'b0;
          addr_r  <= pc_r;
        end
        S_FETCH: begin
          if (mem_ready_i) begin
            ir_r    <= mem_rdata_i;
            npc_r   <= pc_r + 32'd4;
            req_r   <= 1'b0;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_r <= rs_val_s;
          b_r <= rt_val_s;
          if (!legal_s) begin
            halt_r  <= 1'b1;
            state_r <= S_HALT;
          end else if (opcode_s == OP_J || opcode_s == OP_JAL) begin
            if (opcode_s == OP_JAL) begin
              rf_r[31] <= npc_r;
            end
            pc_r      <= jump_target_s;
            instret_r <= instret_r + INSTRET_ONE;
            req_r     <= 1'b1;
            addr_r    <= jump_target_s;
            state_r   <= S_FETCH;
          end else if (is_jr_s) begin
            pc_r      <= rs_val_s;
            instret_r <= instret_r + INSTRET_ONE;
            req_r     <= 1'b1;
            addr_r    <= rs_val_s;
            state_r   <= S_FETCH;
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out_r <= alu_s;
          case (opcode_s)
            OP_BEQ, OP_BNE: begin
              pc_r      <= take_branch_s ? branch_target_s : npc_r;
              addr_r    <= take_branch_s ? branch_target_s : npc_r;
              instret_r <= instret_r + INSTRET_ONE;
              req_r     <= 1'b1;
              state_r   <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              if (alu_s[1:0] != 2'b00) begin
                halt_r  <= 1'b1;
                state_r <= S_HALT;
              end else begin
                req_r   <= 1'b1;
                we_r    <= (opcode_s == OP_SW);
                addr_r  <= alu_s;
                wdata_r <= b_r;
                state_r <= S_MEM;
              end
            end
            default: state_r <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready_i) begin
            we_r <= 1'b0;
            if (we_r) begin
              pc_r      <= npc_r;
              addr_r    <= npc_r;
              instret_r <= instret_r + INSTRET_ONE;
              state_r   <= S_FETCH;
            end else begin
              mdr_r   <= mem_rdata_i;
              req_r   <= 1'b0;
              state_r <= S_WB;
            end
          end
        end
        S_WB: begin
          if (dest_s != 5'd0) begin
            rf_r[dest_s] <= wb_data_s;
          end
          pc_r      <= npc_r;
          addr_r    <= npc_r;
          instret_r <= instret_r + INSTRET_ONE;
          req_r     <= 1'b1;
          state_r   <= S_FETCH;
        end
        S_HALT: begin
          req_r <= 1'b0;
        end
        default: begin
          req_r   <= 1'b0;
          halt_r  <= 1'b1;
          state_r <= S_HALT;
        end
      endcase
    end
  end

endmodule
